// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
// Stalls EX while iterating, then presents a registered result for one cycle.
module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_BPC = 1
) (
  input  logic            clk,
  input  logic            rst_pipe,
  input  logic            req_ex,
  input  logic [2:0]      op_ex,
  input  logic [XLEN-1:0] rs1_ex,
  input  logic [XLEN-1:0] rs2_ex,
  input  logic [4:0]      rd_adr_ex,
  input  logic            kill,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_adr_out
);

  localparam int NIT     = XLEN / DIV_BPC;
  localparam int CNT_W   = $clog2(NIT + MUL_LAT + 1);
  localparam int PW      = 2 * XLEN + 2;
  localparam int MP_D    = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int MP_LAST = MP_D - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_op;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_dvs;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic signed [PW-1:0] r_prod_p [MP_D];
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic              w_sgn_div;
  logic              w_dvs_zero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic signed [PW-1:0] w_ma;
  logic signed [PW-1:0] w_mb;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_mul_src;
  logic [1:0]        w_mul_op;
  logic [XLEN-1:0]   w_mul_res;
  logic [2*XLEN-1:0] w_div_nx;
  logic [XLEN-1:0]   w_div_res;
  logic              w_unused_prod;

  function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] p, input logic [1:0] op);
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Restoring step(s): shift one dividend bit into the partial remainder, subtract if it fits.
  function automatic logic [2*XLEN-1:0] div_iter(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvs);
    logic [XLEN:0]   t;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] q;
    r = rem;
    q = quo;
    for (int b = 0; b < DIV_BPC; b++) begin
      t = {r, q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (t >= {1'b0, dvs}) begin
        t    = t - {1'b0, dvs};
        q[0] = 1'b1;
      end
      r = t[XLEN-1:0];
    end
    return {r, q};
  endfunction

  function automatic logic [XLEN-1:0] div_fix(input logic [XLEN-1:0] rem,
                                              input logic [XLEN-1:0] quo,
                                              input logic [1:0]      op,
                                              input logic            neg_q,
                                              input logic            neg_r);
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    q = neg_q ? -quo : quo;
    r = neg_r ? -rem : rem;
    return op[1] ? r : q;
  endfunction

  // Divide operand conditioning and the divide-by-zero / overflow shortcut
  assign w_sgn_div  = ~op_ex[0];
  assign w_dvs_zero = (rs2_ex == '0);
  assign w_ovf      = w_sgn_div & (rs1_ex == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_ex);
  assign w_a_mag    = (w_sgn_div & rs1_ex[XLEN-1]) ? -rs1_ex : rs1_ex;
  assign w_b_mag    = (w_sgn_div & rs2_ex[XLEN-1]) ? -rs2_ex : rs2_ex;
  assign w_fast_res = w_dvs_zero ? (op_ex[1] ? rs1_ex : '1)
                                 : (op_ex[1] ? '0 : rs1_ex);

  // MULHSU treats rs1 as signed and rs2 as unsigned; MULHU both unsigned
  assign w_a_sgn = (op_ex[1:0] != 2'b11);
  assign w_b_sgn = ~op_ex[1];
  assign w_ma    = {{(XLEN+2){w_a_sgn & rs1_ex[XLEN-1]}}, rs1_ex};
  assign w_mb    = {{(XLEN+2){w_b_sgn & rs2_ex[XLEN-1]}}, rs2_ex};
  assign w_prod  = w_ma * w_mb;

  assign w_mul_src     = (MUL_LAT == 1) ? w_prod : r_prod_p[MP_LAST];
  assign w_mul_op      = (MUL_LAT == 1) ? op_ex[1:0] : r_op;
  assign w_mul_res     = mul_sel(w_mul_src[2*XLEN-1:0], w_mul_op);
  assign w_unused_prod = ^w_mul_src[PW-1:2*XLEN];

  assign w_div_nx  = div_iter(r_rem, r_quo, r_dvs);
  assign w_div_res = div_fix(w_div_nx[2*XLEN-1:XLEN], w_div_nx[XLEN-1:0], r_op, r_neg_q, r_neg_r);

  // Control: state, iteration counter and the retiring result
  always_ff @(posedge clk) begin
    if (rst_pipe) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (kill) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_ex) begin
            if (!op_ex[2]) begin
              if (MUL_LAT == 1) begin
                r_state  <= S_DONE;
                r_result <= w_mul_res;
                r_rd_out <= rd_adr_ex;
              end else begin
                r_state <= S_MUL;
                r_cnt   <= CNT_W'(MUL_LAT - 2);
              end
            end else if (w_dvs_zero | w_ovf) begin
              r_state  <= S_DONE;
              r_result <= w_fast_res;
              r_rd_out <= rd_adr_ex;
            end else begin
              r_state <= S_DIV;
              r_cnt   <= CNT_W'(NIT - 1);
            end
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_result <= w_mul_res;
            r_rd_out <= r_rd;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_result <= w_div_res;
            r_rd_out <= r_rd;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath stage: operand capture, divider iteration, multiplier pipeline
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_ex) begin
      r_op    <= op_ex[1:0];
      r_rd    <= rd_adr_ex;
      r_dvs   <= w_b_mag;
      r_quo   <= w_a_mag;
      r_rem   <= '0;
      r_neg_q <= w_sgn_div & (rs1_ex[XLEN-1] ^ rs2_ex[XLEN-1]);
      r_neg_r <= w_sgn_div & rs1_ex[XLEN-1];
    end else if (r_state == S_DIV) begin
      r_rem <= w_div_nx[2*XLEN-1:XLEN];
      r_quo <= w_div_nx[XLEN-1:0];
    end
    r_prod_p[0] <= w_prod;
    for (int i = 1; i < MP_D; i++) begin
      r_prod_p[i] <= r_prod_p[i-1];
    end
  end

  assign stall_req  = ~kill & (((r_state == S_IDLE) & req_ex) | (r_state == S_MUL) | (r_state == S_DIV));
  assign done       = (r_state == S_DONE) & ~kill;
  assign result     = r_result;
  assign rd_adr_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance (MUL_LAT=2, DIV_BPC=1)
// and a 64-bit instance (MUL_LAT=4, DIV_BPC=2) sharing clock, reset and kill.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_pipe;
  logic        kill;

  logic        req32, stall32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
  logic [4:0]  rd32, rdo32;

  logic        req64, stall64, done64;
  logic [2:0]  op64;
  logic [63:0] a64, b64, res64;
  logic [4:0]  rd64, rdo64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_LAT(2), .DIV_BPC(1)) dut32 (
    .clk(clk), .rst_pipe(rst_pipe), .req_ex(req32), .op_ex(op32),
    .rs1_ex(a32), .rs2_ex(b32), .rd_adr_ex(rd32), .kill(kill),
    .stall_req(stall32), .done(done32), .result(res32), .rd_adr_out(rdo32)
  );

  muldiv_unit #(.XLEN(64), .MUL_LAT(4), .DIV_BPC(2)) dut64 (
    .clk(clk), .rst_pipe(rst_pipe), .req_ex(req64), .op_ex(op64),
    .rs1_ex(a64), .rs2_ex(b64), .rd_adr_ex(rd64), .kill(kill),
    .stall_req(stall64), .done(done64), .result(res64), .rd_adr_out(rdo64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the next cycle, hold req_ex while stalled, measure done latency.
  task automatic do_op(input bit w64, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input int lat,
                       input logic [63:0] exp, input string tag);
    int k;
    bit stall_ok;
    tick();
    kill = 1'b0;
    if (w64) begin
      req64 = 1'b1; op64 = op; a64 = a; b64 = b; rd64 = rd;
    end else begin
      req32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0]; rd32 = rd;
    end
    #1;
    stall_ok = 1'b1;
    k = 0;
    while (k < 100) begin
      if ((w64 ? stall64 : stall32) !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      k++;
      if ((w64 ? done64 : done32) === 1'b1) break;
    end
    check({tag, ".lat"}, k, lat);
    check({tag, ".res"}, w64 ? res64 : {32'b0, res32}, exp);
    check({tag, ".rd"}, w64 ? rdo64 : rdo32, rd);
    check({tag, ".stall"}, {stall_ok, (w64 ? stall64 : stall32)}, 2'b10);
    if (w64) req64 = 1'b0;
    else     req32 = 1'b0;
  endtask

  initial begin
    bit saw_done;
    rst_pipe = 1'b1; kill = 1'b0;
    req32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; rd32 = '0;
    req64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; rd64 = '0;
    tick();
    tick();
    check("rst.stall32", stall32, 1'b0);
    check("rst.done32", done32, 1'b0);
    check("rst.res32", res32, 32'h0);
    check("rst.rd32", rdo32, 5'd0);
    check("rst.done64", done64, 1'b0);
    check("rst.res64", res64, 64'h0);
    rst_pipe = 1'b0;

    do_op(0, 3'b001, 64'h80000000, 64'h80000000, 5'd1, 2, 64'h40000000, "mulh");
    do_op(0, 3'b000, 64'h80000000, 64'h80000000, 5'd2, 2, 64'h00000000, "mul");
    do_op(0, 3'b010, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd3, 2, 64'hFFFFFFFF, "mulhsu");
    do_op(0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd4, 2, 64'hFFFFFFFE, "mulhu");

    do_op(0, 3'b100, 64'hFFFFFFF9, 64'h2, 5'd5, 33, 64'hFFFFFFFD, "div");
    do_op(0, 3'b110, 64'hFFFFFFF9, 64'h2, 5'd6, 33, 64'hFFFFFFFF, "rem");
    do_op(0, 3'b101, 64'd100, 64'd7, 5'd7, 33, 64'd14, "divu");
    do_op(0, 3'b111, 64'd100, 64'd7, 5'd8, 33, 64'd2, "remu");

    do_op(0, 3'b100, 64'd5, 64'd0, 5'd9, 1, 64'hFFFFFFFF, "div0");
    do_op(0, 3'b110, 64'd5, 64'd0, 5'd10, 1, 64'd5, "rem0");
    do_op(0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 5'd11, 1, 64'h80000000, "divovf");
    do_op(0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 5'd12, 1, 64'h0, "removf");

    // Kill a divide at T+10, then a multiply accepted at T+11
    tick();
    req32 = 1'b1; op32 = 3'b100; a32 = 32'd1000; b32 = 32'd3; rd32 = 5'd13;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done32 === 1'b1) saw_done = 1'b1;
    end
    kill = 1'b1; req32 = 1'b0;
    #1;
    check("kill.stall", stall32, 1'b0);
    check("kill.done", {saw_done, done32}, 2'b00);
    do_op(0, 3'b000, 64'h12345, 64'h100, 5'd14, 2, 64'h01234500, "mulkill");

    // Reset while a multiply is in flight
    tick();
    req32 = 1'b1; op32 = 3'b000; a32 = 32'd7; b32 = 32'd6; rd32 = 5'd15;
    tick();
    rst_pipe = 1'b1; req32 = 1'b0;
    tick();
    check("rstmul.done", done32, 1'b0);
    check("rstmul.res", res32, 32'h0);
    check("rstmul.rd", rdo32, 5'd0);
    check("rstmul.stall", stall32, 1'b0);
    rst_pipe = 1'b0;
    tick();
    check("rstmul.nodone", done32, 1'b0);

    // Reset in the done cycle
    do_op(0, 3'b101, 64'd100, 64'd7, 5'd9, 33, 64'd14, "divu2");
    rst_pipe = 1'b1;
    tick();
    check("rstdone.done", done32, 1'b0);
    check("rstdone.res", res32, 32'h0);
    check("rstdone.rd", rdo32, 5'd0);
    rst_pipe = 1'b0;
    do_op(0, 3'b000, 64'd3, 64'd5, 5'd16, 2, 64'd15, "mulpost");

    do_op(1, 3'b101, 64'h8000000000000000, 64'd3, 5'd20, 33, 64'h2AAAAAAAAAAAAAAA, "divu64");
    do_op(1, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd21, 4,
          64'hFFFFFFFFFFFFFFFE, "mulhu64");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
